// File: rtl/bss_pkg.sv
// ============================================================================
// Module : bss_pkg
// Brief  : Shared types and constants for the bit-serial subtractor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bss_pkg;

    localparam int BSS_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bss_state_t;

endpackage

`default_nettype wire

// File: rtl/full_subtractor.sv
// ============================================================================
// Module : full_subtractor
// Brief  : One-bit combinational full-subtractor cell (x - y - bin).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module full_subtractor (
    input  logic i_x,
    input  logic i_y,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);

    assign o_d    = i_x ^ i_y ^ i_bin;
    assign o_bout = (~i_x & i_y) | (~(i_x ^ i_y) & i_bin);

endmodule

`default_nettype wire

// File: rtl/bit_serial_subtractor.sv
// ============================================================================
// Module : bit_serial_subtractor
// Brief  : LSB-first serial a - b, one bit per clock through a single cell.
//          Optional signed-overflow output enabled by macro BSS_OVF_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bit_serial_subtractor
    import bss_pkg::*;
#(
    parameter int WIDTH = BSS_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
`ifdef BSS_OVF_EN
    output logic             o_ovf,
`endif
    output logic             o_borrow
);

    localparam int              CW     = $clog2(WIDTH);
    localparam logic [CW-1:0]   C_LAST = CW'(WIDTH - 1);

    bss_state_t       r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_res;
    logic [CW-1:0]    r_cnt;
    logic             r_bff;
    logic             r_borrow;
`ifdef BSS_OVF_EN
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_ovf;
`endif

    logic w_d;
    logic w_bout;

    full_subtractor u_cell (
        .i_x    (r_a_sr[0]),
        .i_y    (r_b_sr[0]),
        .i_bin  (r_bff),
        .o_d    (w_d),
        .o_bout (w_bout)
    );

    // Result register is shifted in place, so diff stays stable until the
    // first shift of the next operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_res    <= '0;
            r_cnt    <= '0;
            r_bff    <= 1'b0;
            r_borrow <= 1'b0;
`ifdef BSS_OVF_EN
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_ovf    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (i_start) begin
                        r_a_sr  <= i_a;
                        r_b_sr  <= i_b;
                        r_cnt   <= '0;
                        r_bff   <= 1'b0;
`ifdef BSS_OVF_EN
                        r_a_msb <= i_a[WIDTH-1];
                        r_b_msb <= i_b[WIDTH-1];
`endif
                        r_state <= SHIFT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SHIFT: begin
                    r_res  <= {w_d, r_res[WIDTH-1:1]};
                    r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
                    r_bff  <= w_bout;
                    if (r_cnt == C_LAST) begin
                        r_cnt    <= '0;
                        r_borrow <= w_bout;
`ifdef BSS_OVF_EN
                        // w_d is the MSB of the difference on this last bit.
                        r_ovf    <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
`endif
                        r_state  <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy   = (r_state == SHIFT);
    assign o_done   = (r_state == DONE);
    assign o_diff   = r_res;
    assign o_borrow = r_borrow;
`ifdef BSS_OVF_EN
    assign o_ovf    = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bit_serial_subtractor.sv
// ============================================================================
// Module : tb_bit_serial_subtractor
// Brief  : Scoreboard bench for bit_serial_subtractor (WIDTH=8); ovf checks
//          are active when BSS_OVF_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bit_serial_subtractor;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         i_start;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_diff;
    logic         o_borrow;
`ifdef BSS_OVF_EN
    logic         o_ovf;
`endif

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    bit_serial_subtractor #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (i_start),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_diff   (o_diff),
`ifdef BSS_OVF_EN
        .o_ovf    (o_ovf),
`endif
        .o_borrow (o_borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   sd;
        e.diff   = a - b;
        e.borrow = (a < b);
        sd       = int'($signed(a)) - int'($signed(b));
        e.ovf    = (sd > 127) || (sd < -128);
        return e;
    endfunction

    // Waits for done after an accepted start (accepting edge counted as 1),
    // checks the latency, then pops and compares the scoreboard entry.
    task automatic wait_and_score(input string name);
        exp_t e;
        int   n;
        n = 1;
        while (!o_done && n < 40) begin
            checks++;
            if (o_busy !== 1'b1) begin
                failures++;
                $display("FAIL %s busy: got %b need 1 at edge %0d", name, o_busy, n);
            end
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != W + 1) begin
            failures++;
            $display("FAIL %s latency: got %0d edges need %0d", name, n, W + 1);
        end
        checks++;
        if (o_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_at_done: got %b need 0", name, o_busy);
        end
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL %s scoreboard: got empty queue need entry", name);
        end else begin
            e = sb_q.pop_front();
            checks++;
            if (o_diff !== e.diff) begin
                failures++;
                $display("FAIL %s diff: got %h need %h", name, o_diff, e.diff);
            end
            checks++;
            if (o_borrow !== e.borrow) begin
                failures++;
                $display("FAIL %s borrow: got %b need %b", name, o_borrow, e.borrow);
            end
`ifdef BSS_OVF_EN
            checks++;
            if (o_ovf !== e.ovf) begin
                failures++;
                $display("FAIL %s ovf: got %b need %b", name, o_ovf, e.ovf);
            end
`endif
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
        @(negedge clk);
        i_a     = a;
        i_b     = b;
        i_start = 1'b1;
        sb_q.push_back(model(a, b));
        @(posedge clk); #1;
        i_start = 1'b0;
        wait_and_score(name);
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        i_start = 1'b0;
        i_a     = '0;
        i_b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({o_busy, o_done, o_diff, o_borrow} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b diff=%h borrow=%b need all 0",
                     o_busy, o_done, o_diff, o_borrow);
        end
`ifdef BSS_OVF_EN
        checks++;
        if (o_ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_ovf: got %b need 0", o_ovf);
        end
`endif
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_start: got busy=%b done=%b need 0 0", o_busy, o_done);
        end
    endtask

    task automatic test_basic;
        run_op(8'd5,   8'd3,   "5-3");
        run_op(8'd3,   8'd5,   "3-5");
        run_op(8'd0,   8'd0,   "0-0");
        run_op(8'h80,  8'h01,  "80-01");
        run_op(8'hFF,  8'h01,  "FF-01");
        run_op(8'h7F,  8'hFF,  "7F-FF");
        run_op(8'hA5,  8'h5A,  "A5-5A");
        // Result must hold while idle.
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (o_diff !== 8'h4B || o_borrow !== 1'b0) begin
            failures++;
            $display("FAIL hold_idle: got diff=%h borrow=%b need 4b 0", o_diff, o_borrow);
        end
    endtask

    // Bit 1 sees borrow-in from bit 0: a0=0, b0=bin forces bout0=bin.
    task automatic test_cell_truth;
        logic [1:0] tt_d;
        logic [7:0] tt_d_tab;
        logic [7:0] tt_b_tab;
        logic       x, y, bin;
        tt_d_tab = 8'b1001_0110;
        tt_b_tab = 8'b1000_1110;
        for (int i = 0; i < 8; i++) begin
            x   = i[2];
            y   = i[1];
            bin = i[0];
            run_op({6'd0, x, 1'b0}, {6'd0, y, bin}, "cell");
            tt_d = {tt_b_tab[i], tt_d_tab[i]};
            checks++;
            if (o_diff[1] !== tt_d[0] || o_borrow !== tt_d[1]) begin
                failures++;
                $display("FAIL cell_truth xyb=%b%b%b: got d=%b bout=%b need d=%b bout=%b",
                         x, y, bin, o_diff[1], o_borrow, tt_d[0], tt_d[1]);
            end
        end
    endtask

    task automatic test_start_ignored;
        @(negedge clk);
        i_a     = 8'd5;
        i_b     = 8'd3;
        i_start = 1'b1;
        sb_q.push_back(model(8'd5, 8'd3));
        @(posedge clk); #1;
        i_a = 8'h11;
        i_b = 8'h22;
        repeat (4) @(posedge clk);
        #1;
        i_start = 1'b0;
        i_a     = 8'hEE;
        i_b     = 8'h01;
        // Four shift edges have already passed since the accept.
        begin
            exp_t e;
            int   n;
            n = 5;
            while (!o_done && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            checks++;
            if (n != W + 1) begin
                failures++;
                $display("FAIL ignore_latency: got %0d need %0d", n, W + 1);
            end
            e = sb_q.pop_front();
            checks++;
            if (o_diff !== e.diff || o_borrow !== e.borrow) begin
                failures++;
                $display("FAIL ignore_result: got diff=%h borrow=%b need %h %b",
                         o_diff, o_borrow, e.diff, e.borrow);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            failures++;
            $display("FAIL ignore_no_requeue: got busy=%b done=%b need 0 0", o_busy, o_done);
        end
    endtask

    task automatic test_back_to_back;
        run_op(8'd9, 8'd4, "b2b_first");
        // Now sampling inside the DONE cycle: issue the next request here.
        i_a     = 8'h10;
        i_b     = 8'h20;
        i_start = 1'b1;
        sb_q.push_back(model(8'h10, 8'h20));
        @(posedge clk); #1;
        i_start = 1'b0;
        checks++;
        if (o_busy !== 1'b1 || o_done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept: got busy=%b done=%b need 1 0", o_busy, o_done);
        end
        wait_and_score("b2b_second");
    endtask

    task automatic test_reset_mid;
        int seen_done;
        @(negedge clk);
        i_a     = 8'h55;
        i_b     = 8'h11;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_busy !== 1'b0 || o_diff !== 8'h00 || o_done !== 1'b0 || o_borrow !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: got busy=%b diff=%h done=%b borrow=%b need 0 00 0 0",
                     o_busy, o_diff, o_done, o_borrow);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        seen_done = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (o_done === 1'b1) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            failures++;
            $display("FAIL reset_no_done: got %0d done pulses need 0", seen_done);
        end
        run_op(8'd7, 8'd2, "after_reset_7-2");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cell_truth();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d left need 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
